seq_alu: RTL and testbench



---
 rtl/seq_alu.sv | 151 +++++++++++++++
 tb/tb_seq_alu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops finish in 1 cycle, MUL (shift-add) and DIV/MOD (restoring) in WIDTH+1.
// Valid/ready on both sides; Result and flags hold in DONE until OutReady, so a stalled consumer never loses data.
module seq_alu #(
   parameter int WIDTH = 19,
   parameter int OPW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OPW-1:0]   ALUControl,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Result,
   output logic             Negative,
   output logic             Zero,
   output logic             DivByZero,
   output logic             IllegalOp
);
   localparam int SW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [OPW-1:0] OP_ADD = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB = OPW'(1);
   localparam logic [OPW-1:0] OP_MUL = OPW'(2);
   localparam logic [OPW-1:0] OP_DIV = OPW'(3);
   localparam logic [OPW-1:0] OP_INC = OPW'(4);
   localparam logic [OPW-1:0] OP_DEC = OPW'(5);
   localparam logic [OPW-1:0] OP_AND = OPW'(6);
   localparam logic [OPW-1:0] OP_OR  = OPW'(7);
   localparam logic [OPW-1:0] OP_XOR = OPW'(8);
   localparam logic [OPW-1:0] OP_NOT = OPW'(9);
   localparam logic [OPW-1:0] OP_MOD = OPW'(13);
   localparam logic [OPW-1:0] OP_SHL = OPW'(14);
   localparam logic [OPW-1:0] OP_SHR = OPW'(15);

   logic [1:0]       state;
   logic [SW-1:0]    cnt;
   logic [WIDTH-1:0] a_q, b_q, acc, quo;
   logic             is_mod;

   logic [SW-1:0]    sh_amt;
   logic             sh_big;
   logic [WIDTH-1:0] fast_res;
   logic             fast_ill, is_mul, is_dm, dz_now;
   logic [WIDTH-1:0] mul_next, rem_next, quo_next;
   logic [WIDTH:0]   trial, diff;
   logic             ge;

   always_comb begin
      sh_amt   = B[SW-1:0];
      sh_big   = 32'(sh_amt) >= WIDTH;
      fast_res = '0;
      fast_ill = 1'b0;
      case (ALUControl)
         OP_ADD: fast_res = A + B;
         OP_SUB: fast_res = A - B;
         OP_INC: fast_res = A + WIDTH'(1);
         OP_DEC: fast_res = A - WIDTH'(1);
         OP_AND: fast_res = A & B;
         OP_OR:  fast_res = A | B;
         OP_XOR: fast_res = A ^ B;
         OP_NOT: fast_res = ~A;
         OP_SHL: fast_res = sh_big ? '0 : A << sh_amt;
         OP_SHR: fast_res = sh_big ? '0 : A >> sh_amt;
         // long ops produce their result later; the divide-by-zero bypass returns 0
         OP_MUL, OP_DIV, OP_MOD: fast_res = '0;
         default: fast_ill = 1'b1;
      endcase
      is_mul = ALUControl == OP_MUL;
      is_dm  = (ALUControl == OP_DIV) || (ALUControl == OP_MOD);
      dz_now = is_dm && (B == '0);
   end

   // MSB-first shift-add and restoring divide; the borrow bit of diff decides each quotient bit
   always_comb begin
      mul_next = {acc[WIDTH-2:0], 1'b0} + (b_q[cnt] ? a_q : '0);
      trial    = {acc, a_q[cnt]};
      diff     = trial - {1'b0, b_q};
      ge       = ~diff[WIDTH];
      rem_next = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc       <= '0;
         quo       <= '0;
         is_mod    <= 1'b0;
         Result    <= '0;
         DivByZero <= 1'b0;
         IllegalOp <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (InValid) begin
               a_q       <= A;
               b_q       <= B;
               is_mod    <= ALUControl == OP_MOD;
               acc       <= '0;
               quo       <= '0;
               cnt       <= SW'(WIDTH - 1);
               DivByZero <= dz_now;
               IllegalOp <= fast_ill;
               if (is_mul) begin
                  state <= S_MUL;
               end else if (is_dm && !dz_now) begin
                  state <= S_DIV;
               end else begin
                  state  <= S_DONE;
                  Result <= fast_res;
               end
            end
            S_MUL: begin
               acc <= mul_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  state  <= S_DONE;
                  Result <= mul_next;
               end
            end
            S_DIV: begin
               acc <= rem_next;
               quo <= quo_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  state  <= S_DONE;
                  Result <= is_mod ? rem_next : quo_next;
               end
            end
            S_DONE: if (OutReady) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign InReady  = state == S_IDLE;
   assign OutValid = state == S_DONE;
   assign Negative = Result[WIDTH-1];
   assign Zero     = Result == '0;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed plan steps plus random ops against an arithmetic reference model.
module tb_seq_alu;
   logic        clk, rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [18:0] a, b, result;
   logic [4:0]  op;
   logic        neg, zero, dbz, ill;

   logic        iv8, ir8, ov8, or8;
   logic [7:0]  a8, b8, res8;
   logic [4:0]  op8;
   logic        neg8, zero8, dbz8, ill8;

   int checks   = 0;
   int failures = 0;

   seq_alu #(.WIDTH(19), .OPW(5)) dut (
      .clk(clk), .rst(rst), .InValid(in_valid), .InReady(in_ready),
      .A(a), .B(b), .ALUControl(op), .OutValid(out_valid), .OutReady(out_ready),
      .Result(result), .Negative(neg), .Zero(zero), .DivByZero(dbz), .IllegalOp(ill)
   );

   seq_alu #(.WIDTH(8), .OPW(5)) dut8 (
      .clk(clk), .rst(rst), .InValid(iv8), .InReady(ir8),
      .A(a8), .B(b8), .ALUControl(op8), .OutValid(ov8), .OutReady(or8),
      .Result(res8), .Negative(neg8), .Zero(zero8), .DivByZero(dbz8), .IllegalOp(ill8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: results straight from the opcode table, with mod 2^w masking.
   function automatic void model(input int w, input logic [4:0] o, input logic [63:0] x, input logic [63:0] y,
                                 output logic [63:0] r, output bit dz, output bit il, output int lat);
      logic [63:0] m, sh;
      int sb;
      m  = (64'd1 << w) - 64'd1;
      sb = 0;
      while ((1 << sb) < w) sb++;
      sh  = y & ((64'd1 << sb) - 64'd1);
      r   = 64'd0;
      dz  = 1'b0;
      il  = 1'b0;
      lat = 1;
      case (o)
         5'd0:  r = x + y;
         5'd1:  r = x - y;
         5'd2:  begin r = x * y; lat = w + 1; end
         5'd3, 5'd13: begin
            if (y == 64'd0) dz = 1'b1;
            else begin
               r   = (o == 5'd3) ? x / y : x % y;
               lat = w + 1;
            end
         end
         5'd4:  r = x + 64'd1;
         5'd5:  r = x - 64'd1;
         5'd6:  r = x & y;
         5'd7:  r = x | y;
         5'd8:  r = x ^ y;
         5'd9:  r = ~x;
         5'd14: r = (sh >= 64'(w)) ? 64'd0 : x << sh;
         5'd15: r = (sh >= 64'(w)) ? 64'd0 : x >> sh;
         default: il = 1'b1;
      endcase
      r = r & m;
   endfunction

   task automatic run_op(input string tag, input logic [4:0] o, input logic [18:0] xa, input logic [18:0] xb,
                         input int stall);
      logic [63:0] er;
      bit edz, eil;
      int elat, lat, guard;
      model(19, o, 64'(xa), 64'(xb), er, edz, eil, elat);
      op = o; a = xa; b = xb; in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      check({tag, " in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      // scramble inputs so a design that fails to latch them is exposed
      in_valid = 1'b0; a = 19'($urandom); b = 19'($urandom); op = 5'($urandom);
      lat = 1;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      check({tag, " latency"}, 64'(lat), 64'(elat));
      check({tag, " result"}, 64'(result), er);
      check({tag, " negative"}, 64'(neg), 64'(er[18]));
      check({tag, " zero"}, 64'(zero), 64'(er == 64'd0));
      check({tag, " divbyzero"}, 64'(dbz), 64'(edz));
      check({tag, " illegal"}, 64'(ill), 64'(eil));
      repeat (stall) begin
         @(posedge clk); #1;
         check({tag, " hold valid"}, 64'(out_valid), 64'd1);
         check({tag, " hold result"}, 64'(result), er);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " valid drop"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [63:0] er8;
      bit edz8, eil8;
      int elat8, lat8, stray;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst in_ready", 64'(in_ready), 64'd1);
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst result", 64'(result), 64'd0);
      check("rst zero", 64'(zero), 64'd1);
      check("rst negative", 64'(neg), 64'd0);
      check("rst divbyzero", 64'(dbz), 64'd0);
      check("rst illegal", 64'(ill), 64'd0);
      rst = 1'b0;

      run_op("add_wrap", 5'h00, 19'h7FFFF, 19'h00001, 0);
      run_op("sub_wrap", 5'h01, 19'h00000, 19'h00001, 0);
      run_op("mul_1000x600", 5'h02, 19'd1000, 19'd600, 0);
      run_op("mul_max", 5'h02, 19'h7FFFF, 19'h7FFFF, 0);
      run_op("div_100000_7", 5'h03, 19'd100000, 19'd7, 0);
      run_op("mod_100000_7", 5'h0D, 19'd100000, 19'd7, 2);
      run_op("div_by_zero", 5'h03, 19'd5, 19'd0, 0);
      run_op("mod_by_zero", 5'h0D, 19'd9, 19'd0, 0);
      run_op("illegal_0b", 5'h0B, 19'h12345, 19'h00321, 0);
      run_op("add_clears", 5'h00, 19'd3, 19'd4, 0);
      run_op("reserved_0a", 5'h0A, 19'h00001, 19'h00001, 0);
      run_op("shl_18", 5'h0E, 19'd1, 19'd18, 0);
      run_op("shl_19", 5'h0E, 19'd1, 19'd19, 0);
      run_op("shr_18", 5'h0F, 19'h40000, 19'd18, 0);
      run_op("inc_wrap", 5'h04, 19'h7FFFF, 19'd0, 0);
      run_op("dec_wrap", 5'h05, 19'd0, 19'd0, 0);
      run_op("not", 5'h09, 19'h0F0F0, 19'd0, 1);
      run_op("div_small", 5'h03, 19'd6, 19'h7FFFF, 0);

      // backpressure: XOR held in DONE while a second op is offered
      check("bp in_ready", 64'(in_ready), 64'd1);
      op = 5'h08; a = 19'h55555; b = 19'h2AAAA; in_valid = 1'b1;
      @(posedge clk); #1;
      op = 5'h00; a = 19'd1; b = 19'd1;
      for (int i = 0; i < 10; i++) begin
         check("bp valid", 64'(out_valid), 64'd1);
         check("bp result", 64'(result), 64'h7FFFF);
         check("bp in_ready busy", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp valid drop", 64'(out_valid), 64'd0);
      check("bp in_ready back", 64'(in_ready), 64'd1);
      stray = 0;
      repeat (25) begin @(posedge clk); #1; if (out_valid) stray++; end
      check("bp ignored op", 64'(stray), 64'd0);

      for (int i = 0; i < 40; i++) begin
         logic [4:0]  ro;
         logic [18:0] ra, rb;
         ro = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
         ra = 19'($urandom);
         case ($urandom_range(0, 3))
            0: rb = '0;
            1: rb = 19'($urandom_range(0, 31));
            default: rb = 19'($urandom);
         endcase
         run_op("rand", ro, ra, rb, int'($urandom_range(0, 2)));
      end

      // reset during a divide discards it
      run_op("pre_rst_add", 5'h00, 19'd3, 19'd4, 0);
      op = 5'h03; a = 19'd100000; b = 19'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("mid_div busy", 64'(in_ready), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst in_ready", 64'(in_ready), 64'd1);
      check("mid_rst out_valid", 64'(out_valid), 64'd0);
      check("mid_rst result", 64'(result), 64'd0);
      check("mid_rst zero", 64'(zero), 64'd1);
      check("mid_rst divbyzero", 64'(dbz), 64'd0);
      stray = 0;
      repeat (30) begin @(posedge clk); #1; if (out_valid) stray++; end
      check("mid_rst no stray", 64'(stray), 64'd0);

      // narrow instance
      model(8, 5'd2, 64'd15, 64'd17, er8, edz8, eil8, elat8);
      op8 = 5'h02; a8 = 8'd15; b8 = 8'd17; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat8 = 1;
      while (!ov8 && lat8 < 100) begin @(posedge clk); #1; lat8++; end
      check("w8 mul latency", 64'(lat8), 64'(elat8));
      check("w8 mul result", 64'(res8), er8);
      check("w8 mul negative", 64'(neg8), 64'(er8[7]));
      check("w8 mul divbyzero", 64'(dbz8), 64'(edz8));
      or8 = 1'b1;
      @(posedge clk); #1;
      check("w8 ready back", 64'(ir8), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
